// File: rtl/register_file_param.sv
// register_file_param: parametrised multi-port register file with a busy
// scoreboard and an NZP condition-code register.
//   - two registered read ports (optional write-through bypass)
//   - main write port plus an auxiliary write port fixed to AUX_REG
//   - busy bit per register: RESV_EN sets, WE clears, set wins on collision
//   - NZP tracks the sign/zero class of the last main-port write
module register_file_param #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned BYPASS  = 1,
  parameter int unsigned AUX_REG = 0
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     WE,
  input  logic [ADDR_W-1:0]        WADDR,
  input  logic [WIDTH-1:0]         WDATA,
  input  logic                     AUX_WE,
  input  logic [WIDTH-1:0]         AUX_DATA,
  input  logic [ADDR_W-1:0]        RS1,
  input  logic [ADDR_W-1:0]        RS2,
  output logic [WIDTH-1:0]         RS1_DATA,
  output logic [WIDTH-1:0]         RS2_DATA,
  output logic                     RS1_BUSY,
  output logic                     RS2_BUSY,
  input  logic                     RESV_EN,
  input  logic [ADDR_W-1:0]        RESV_ADDR,
  output logic [(1<<ADDR_W)-1:0]   BUSY_VEC,
  output logic [2:0]               NZP
);

  localparam int unsigned       NREG    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] AUX_IDX = ADDR_W'(AUX_REG);

  localparam logic [2:0] NZP_N = 3'b100;
  localparam logic [2:0] NZP_Z = 3'b010;
  localparam logic [2:0] NZP_P = 3'b001;

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [NREG-1:0]  busy_q, busy_d;
  logic [2:0]       nzp_q, nzp_d;
  logic [WIDTH-1:0] rs1_data_q, rs1_data_d;
  logic [WIDTH-1:0] rs2_data_q, rs2_data_d;
  logic             rs1_busy_q, rs1_busy_d;
  logic             rs2_busy_q, rs2_busy_d;

  // Register-array next state; main port is applied last so it wins over aux.
  always_comb begin
    regs_d = regs_q;
    if (AUX_WE) regs_d[AUX_IDX] = AUX_DATA;
    if (WE)     regs_d[WADDR]   = WDATA;
  end

  // Scoreboard next state; reservation applied after writeback clear so set wins.
  always_comb begin
    busy_d = busy_q;
    if (WE)      busy_d[WADDR]     = 1'b0;
    if (RESV_EN) busy_d[RESV_ADDR] = 1'b1;
  end

  // Condition codes from main-port write data only.
  always_comb begin
    nzp_d = nzp_q;
    if (WE) begin
      if (WDATA[WIDTH-1])      nzp_d = NZP_N;
      else if (WDATA == '0)    nzp_d = NZP_Z;
      else                     nzp_d = NZP_P;
    end
  end

  // Read-port capture values; busy flags always see this edge's updates.
  always_comb begin
    rs1_data_d = (BYPASS != 0) ? regs_d[RS1] : regs_q[RS1];
    rs2_data_d = (BYPASS != 0) ? regs_d[RS2] : regs_q[RS2];
    rs1_busy_d = busy_d[RS1];
    rs2_busy_d = busy_d[RS2];
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      regs_q     <= '{default: '0};
      busy_q     <= '0;
      nzp_q      <= NZP_Z;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rs1_busy_q <= 1'b0;
      rs2_busy_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      nzp_q      <= nzp_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      rs1_busy_q <= rs1_busy_d;
      rs2_busy_q <= rs2_busy_d;
    end
  end

  assign RS1_DATA = rs1_data_q;
  assign RS2_DATA = rs2_data_q;
  assign RS1_BUSY = rs1_busy_q;
  assign RS2_BUSY = rs2_busy_q;
  assign BUSY_VEC = busy_q;
  assign NZP      = nzp_q;

endmodule

// File: tb/tb_register_file_param.sv
// Directed bench for register_file_param: default (bypass), no-bypass and
// wide (32-bit, 16-register, AUX_REG=15) instances.
module tb_register_file_param;

  logic        clk;
  logic        rst_n;

  // Shared stimulus for the two 16-bit instances
  logic        we, aux_we, resv_en;
  logic [2:0]  waddr, rs1, rs2, resv_addr;
  logic [15:0] wdata, aux_data;

  logic [15:0] b_rs1_data, b_rs2_data, n_rs1_data, n_rs2_data;
  logic        b_rs1_busy, b_rs2_busy, n_rs1_busy, n_rs2_busy;
  logic [7:0]  b_busy_vec, n_busy_vec;
  logic [2:0]  b_nzp, n_nzp;

  // Wide instance stimulus
  logic        w_we, w_aux_we, w_resv_en;
  logic [3:0]  w_waddr, w_rs1, w_rs2, w_resv_addr;
  logic [31:0] w_wdata, w_aux_data;
  logic [31:0] w_rs1_data, w_rs2_data;
  logic        w_rs1_busy, w_rs2_busy;
  logic [15:0] w_busy_vec;
  logic [2:0]  w_nzp;

  int unsigned checks;
  int unsigned failures;

  register_file_param #(.WIDTH(16), .ADDR_W(3), .BYPASS(1), .AUX_REG(0)) u_byp (
    .CLK(clk), .RST_N(rst_n), .WE(we), .WADDR(waddr), .WDATA(wdata),
    .AUX_WE(aux_we), .AUX_DATA(aux_data), .RS1(rs1), .RS2(rs2),
    .RS1_DATA(b_rs1_data), .RS2_DATA(b_rs2_data),
    .RS1_BUSY(b_rs1_busy), .RS2_BUSY(b_rs2_busy),
    .RESV_EN(resv_en), .RESV_ADDR(resv_addr), .BUSY_VEC(b_busy_vec), .NZP(b_nzp)
  );

  register_file_param #(.WIDTH(16), .ADDR_W(3), .BYPASS(0), .AUX_REG(0)) u_nob (
    .CLK(clk), .RST_N(rst_n), .WE(we), .WADDR(waddr), .WDATA(wdata),
    .AUX_WE(aux_we), .AUX_DATA(aux_data), .RS1(rs1), .RS2(rs2),
    .RS1_DATA(n_rs1_data), .RS2_DATA(n_rs2_data),
    .RS1_BUSY(n_rs1_busy), .RS2_BUSY(n_rs2_busy),
    .RESV_EN(resv_en), .RESV_ADDR(resv_addr), .BUSY_VEC(n_busy_vec), .NZP(n_nzp)
  );

  register_file_param #(.WIDTH(32), .ADDR_W(4), .BYPASS(1), .AUX_REG(15)) u_wide (
    .CLK(clk), .RST_N(rst_n), .WE(w_we), .WADDR(w_waddr), .WDATA(w_wdata),
    .AUX_WE(w_aux_we), .AUX_DATA(w_aux_data), .RS1(w_rs1), .RS2(w_rs2),
    .RS1_DATA(w_rs1_data), .RS2_DATA(w_rs2_data),
    .RS1_BUSY(w_rs1_busy), .RS2_BUSY(w_rs2_busy),
    .RESV_EN(w_resv_en), .RESV_ADDR(w_resv_addr), .BUSY_VEC(w_busy_vec), .NZP(w_nzp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; aux_we = 1'b0; resv_en = 1'b0;
    waddr = '0; wdata = '0; aux_data = '0; resv_addr = '0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    idle();
    rs1 = '0; rs2 = '0;
    w_we = 1'b0; w_aux_we = 1'b0; w_resv_en = 1'b0;
    w_waddr = '0; w_wdata = '0; w_aux_data = '0; w_rs1 = '0; w_rs2 = '0; w_resv_addr = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // ---- Reset asserted mid-operation ----
    we = 1'b1; waddr = 3'd5; wdata = 16'h1111; resv_en = 1'b1; resv_addr = 3'd5;
    rs1 = 3'd5; rs2 = 3'd5;
    tick();
    chk("pre_rst_rs1", 64'(b_rs1_data), 64'h1111);
    chk("pre_rst_busy", 64'(b_busy_vec), 64'h20);
    wdata = 16'h7777;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rs1", 64'(b_rs1_data), 64'h0);
    chk("rst_rs2", 64'(b_rs2_data), 64'h0);
    chk("rst_rs1_busy", 64'(b_rs1_busy), 64'h0);
    chk("rst_busy_vec", 64'(b_busy_vec), 64'h0);
    chk("rst_nzp", 64'(b_nzp), 64'h2);
    tick();
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_r5", 64'(b_rs1_data), 64'h0);
    chk("post_rst_r5_nob", 64'(n_rs1_data), 64'h0);

    // ---- Write/read latency, bypass vs. no bypass ----
    we = 1'b1; waddr = 3'd3; wdata = 16'h8001; rs1 = 3'd3;
    tick();
    chk("byp_rs1", 64'(b_rs1_data), 64'h8001);
    chk("nob_rs1", 64'(n_rs1_data), 64'h0000);
    chk("nzp_neg", 64'(b_nzp), 64'h4);
    idle();
    tick();
    chk("nob_rs1_late", 64'(n_rs1_data), 64'h8001);

    // ---- Port conflict on R0 ----
    we = 1'b1; waddr = 3'd0; wdata = 16'h1234; aux_we = 1'b1; aux_data = 16'hABCD;
    rs1 = 3'd0; rs2 = 3'd0;
    tick();
    chk("conf_rs1", 64'(b_rs1_data), 64'h1234);
    chk("conf_rs2", 64'(b_rs2_data), 64'h1234);
    chk("conf_nzp", 64'(b_nzp), 64'h1);
    idle();
    tick();
    chk("conf_nob_rs1", 64'(n_rs1_data), 64'h1234);
    aux_we = 1'b1; aux_data = 16'h0000;
    tick();
    chk("aux_rs1", 64'(b_rs1_data), 64'h0000);
    chk("aux_nzp", 64'(b_nzp), 64'h1);
    // Distinct targets: both writes land
    idle();
    we = 1'b1; waddr = 3'd2; wdata = 16'h00FF; aux_we = 1'b1; aux_data = 16'h5555;
    rs1 = 3'd2; rs2 = 3'd0;
    tick();
    chk("dual_rs1", 64'(b_rs1_data), 64'h00FF);
    chk("dual_rs2", 64'(b_rs2_data), 64'h5555);

    // ---- Scoreboard ----
    idle();
    resv_en = 1'b1; resv_addr = 3'd6; rs2 = 3'd6;
    tick();
    chk("resv_vec", 64'(b_busy_vec), 64'h40);
    chk("resv_rs2_busy", 64'(b_rs2_busy), 64'h1);
    chk("resv_rs2_busy_nob", 64'(n_rs2_busy), 64'h1);
    we = 1'b1; waddr = 3'd6; wdata = 16'h0042;
    tick();
    chk("reissue_vec", 64'(b_busy_vec), 64'h40);
    chk("reissue_rs2_busy", 64'(b_rs2_busy), 64'h1);
    resv_en = 1'b0;
    tick();
    chk("clear_vec", 64'(b_busy_vec), 64'h00);
    chk("clear_rs2_busy", 64'(b_rs2_busy), 64'h0);
    idle();
    resv_en = 1'b1; resv_addr = 3'd0; rs1 = 3'd0;
    tick();
    resv_en = 1'b0; aux_we = 1'b1; aux_data = 16'h0001;
    tick();
    chk("aux_keeps_busy", 64'(b_busy_vec), 64'h01);
    chk("aux_keeps_rs1_busy", 64'(b_rs1_busy), 64'h1);
    idle();
    we = 1'b1; waddr = 3'd0; wdata = 16'hFFFF;
    tick();
    chk("wb_clears_r0", 64'(b_busy_vec), 64'h00);
    chk("wb_nzp", 64'(b_nzp), 64'h4);
    idle();

    // ---- Wide configuration sweep ----
    for (int i = 0; i < 16; i++) begin
      w_we = 1'b1; w_waddr = 4'(i); w_wdata = 32'(i) * 32'h11111111;
      tick();
    end
    chk("wide_nzp_neg", 64'(w_nzp), 64'h4);
    w_we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      w_rs1 = 4'(i); w_rs2 = 4'(15 - i);
      tick();
      chk("wide_rs1", 64'(w_rs1_data), 64'(32'(i) * 32'h11111111));
      chk("wide_rs2", 64'(w_rs2_data), 64'(32'(15 - i) * 32'h11111111));
    end
    w_we = 1'b1; w_waddr = 4'd0; w_wdata = 32'h0;
    tick();
    chk("wide_nzp_zero", 64'(w_nzp), 64'h2);
    w_we = 1'b1; w_waddr = 4'd15; w_wdata = 32'h12345678;
    w_aux_we = 1'b1; w_aux_data = 32'hDEADBEEF; w_rs1 = 4'd15;
    tick();
    chk("wide_conf", 64'(w_rs1_data), 64'h12345678);
    w_we = 1'b0;
    tick();
    chk("wide_aux", 64'(w_rs1_data), 64'hDEADBEEF);
    w_aux_we = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_file_param.md
Name: register_file_param

Overview:
- Parametrised successor to the LC-3 8x16 register file.
- Configurable data width and register count; two synchronous read ports; a main write port and an auxiliary write port to one fixed register.
- Adds a per-register busy scoreboard (reserve at issue, clear at writeback) and an NZP condition-code register updated on main-port writes.
- Sits between decode/issue (RS1/RS2, reservation) and writeback (WE/WADDR/WDATA) in the LC3 datapath.

Parameters:
- WIDTH, 16: data width in bits; must be at least 2.
- ADDR_W, 3: register address width; register count NREG = 2**ADDR_W.
- BYPASS, 1: 1 = same-edge writes are visible on the read outputs (write-through); 0 = reads return the pre-edge value.
- AUX_REG, 0: register index targeted by the auxiliary write port; must be less than NREG.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RST_N  in  1  asynchronous, active-low reset.
- WE  in  1  main write enable.
- WADDR  in  ADDR_W  main write address.
- WDATA  in  WIDTH  main write data.
- AUX_WE  in  1  auxiliary write enable; targets AUX_REG.
- AUX_DATA  in  WIDTH  auxiliary write data.
- RS1  in  ADDR_W  read address, port 1.
- RS2  in  ADDR_W  read address, port 2.
- RS1_DATA  out  WIDTH  registered read data, port 1.
- RS2_DATA  out  WIDTH  registered read data, port 2.
- RS1_BUSY  out  1  registered busy flag of the RS1 register.
- RS2_BUSY  out  1  registered busy flag of the RS2 register.
- RESV_EN  in  1  reserve a destination register (set its busy bit).
- RESV_ADDR  in  ADDR_W  register to reserve.
- BUSY_VEC  out  NREG  current scoreboard, bit i = register i busy.
- NZP  out  3  condition codes {N,Z,P} from the last main-port write.

Behaviour:
- Reset (RST_N low, asynchronous, takes effect immediately):
  - All registers = 0; RS1_DATA = RS2_DATA = 0; RS1_BUSY = RS2_BUSY = 0.
  - BUSY_VEC = 0; NZP = 3'b010.
  - Reset asserted mid-operation discards all pending reservations and any same-cycle writes.
- Register writes (per posedge):
  - WE: reg[WADDR] <= WDATA.
  - AUX_WE: reg[AUX_REG] <= AUX_DATA.
  - Both enabled with WADDR == AUX_REG: the main port wins and AUX_DATA is dropped.
  - Both enabled with different targets: both writes occur.
- Reads, 1-cycle latency. On each posedge, RSx_DATA captures reg[RSx]:
  - BYPASS=1: the captured value includes this edge's writes, with the same main-over-aux priority. Example: RS1 == WADDR and WE=1 gives RS1_DATA = WDATA after the edge.
  - BYPASS=0: the captured value is the register contents before this edge.
  - Read outputs update every cycle; there is no read enable.
  - RS1 == RS2 is legal; both ports return identical data.
- Scoreboard:
  - WE clears busy[WADDR].
  - RESV_EN sets busy[RESV_ADDR].
  - Same edge, same address: set wins, so the register stays busy (back-to-back reissue).
  - AUX_WE does not affect the scoreboard.
  - Reserving an already-busy register leaves it busy.
  - Clearing a non-busy register is a no-op.
  - RSx_BUSY = busy[RSx] after this edge's updates, independent of BYPASS.
  - BUSY_VEC is the scoreboard register driven directly.
- NZP:
  - Updated only on WE, from WDATA: N = WDATA[WIDTH-1]; Z = (WDATA == 0); P = neither N nor Z.
  - Exactly one bit is set at all times.
  - AUX_WE and reads never change NZP.
- No X outputs in any configuration. Out-of-range addresses cannot occur because NREG = 2**ADDR_W.

Test Plan:
- Reset: drive RST_N low mid-cycle with WE=1 -> outputs, registers and BUSY_VEC read 0 immediately; NZP = 010; after release, read of R5 gives 0.
- Write/read latency, BYPASS=1: WE=1, WADDR=3, WDATA=16'h8001, RS1=3 on the same edge -> RS1_DATA = 8001 after that edge; NZP = 100.
- Same stimulus with BYPASS=0 -> RS1_DATA = 0000 after that edge, 8001 one edge later.
- Port conflict: WE=1, WADDR=0, WDATA=1234 and AUX_WE=1, AUX_DATA=ABCD on one edge -> R0 = 1234; NZP = 001.
- Then AUX_WE only, AUX_DATA=0000 -> R0 = 0000; NZP unchanged at 001.
- Scoreboard: RESV_EN with RESV_ADDR=6 -> BUSY_VEC = 0x40 and RS2_BUSY=1 with RS2=6.
- Next edge: WE to 6 plus RESV_EN to 6 -> BUSY_VEC stays 0x40.
- Following edge: WE to 6 only -> BUSY_VEC = 0x00.
- Parameter sweep: WIDTH=32, ADDR_W=4, AUX_REG=15 -> write all 16 registers with index*0x11111111, read back on both ports, check WDATA=0 gives NZP = 010.
